// File: rtl/nios_system_cpu_0_jtag_debug_host_if.sv
// Command/response handshake bundle for the cpu_0 virtual-JTAG debug host.
// master = requester issuing scans, slave = the scan engine.
interface nios_system_cpu_0_jtag_debug_host_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_data;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );
endinterface

// File: rtl/nios_system_cpu_0_jtag_debug_host.sv
// Virtual-JTAG scan host: one command -> UIR/CDR/SDR x DR_WIDTH/UDR/RTI sequence, DR captured from tdo.
// Latency 1 + (3+DR_WIDTH+RTI_CYCLES)*2*TCK_DIV clk; single outstanding command, response held until rsp_ready.
module nios_system_cpu_0_jtag_debug_host #(
    parameter int TCK_DIV    = 2,
    parameter int DR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    nios_system_cpu_0_jtag_debug_host_if.slave host,
    output logic                busy,
    output logic                vj_tck,
    output logic                vj_tdi,
    input  logic                vj_tdo,
    output logic [IR_WIDTH-1:0] vj_ir_in,
    input  logic [IR_WIDTH-1:0] vj_ir_out,
    output logic                vj_uir,
    output logic                vj_cdr,
    output logic                vj_sdr,
    output logic                vj_udr,
    output logic                vj_rti
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UIR  = 3'd1;
    localparam logic [2:0] S_CDR  = 3'd2;
    localparam logic [2:0] S_SDR  = 3'd3;
    localparam logic [2:0] S_UDR  = 3'd4;
    localparam logic [2:0] S_RTI  = 3'd5;
    localparam logic [2:0] S_RSP  = 3'd6;

    localparam int DIV_W   = $clog2(2 * TCK_DIV);
    localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [DIV_W-1:0] DIV_SAMPLE = DIV_W'(TCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [CNT_W-1:0] SDR_LAST   = CNT_W'(DR_WIDTH - 1);
    localparam logic [CNT_W-1:0] RTI_LAST   = CNT_W'(RTI_CYCLES - 1);

    logic [2:0]          state;
    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    per_cnt;
    logic [DR_WIDTH-1:0] shift;
    logic [DR_WIDTH-1:0] cap;
    logic [DR_WIDTH-1:0] rsp_data_q;
    logic [IR_WIDTH-1:0] rsp_ir_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                rsp_valid_q;
    logic                tck_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            per_cnt     <= '0;
            shift       <= '0;
            cap         <= '0;
            rsp_data_q  <= '0;
            rsp_ir_q    <= '0;
            ir_q        <= '0;
            rsp_valid_q <= 1'b0;
            tck_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host.cmd_valid) begin
                        ir_q    <= host.cmd_ir;
                        shift   <= host.cmd_data;
                        div_cnt <= '0;
                        per_cnt <= '0;
                        state   <= S_UIR;
                    end
                end
                S_RSP: begin
                    if (host.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    // Last low-half cycle: target outputs are stable, tck rises at this edge.
                    if (div_cnt == DIV_SAMPLE) begin
                        tck_q <= 1'b1;
                        if (state == S_UIR) rsp_ir_q <= vj_ir_out;
                        if (state == S_SDR) cap <= {vj_tdo, cap[DR_WIDTH-1:1]};
                    end
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        tck_q   <= 1'b0;
                        case (state)
                            S_UIR: state <= S_CDR;
                            S_CDR: begin
                                per_cnt <= '0;
                                state   <= S_SDR;
                            end
                            S_SDR: begin
                                shift <= shift >> 1;
                                if (per_cnt == SDR_LAST) state <= S_UDR;
                                else per_cnt <= per_cnt + 1'b1;
                            end
                            S_UDR: begin
                                per_cnt <= '0;
                                state   <= S_RTI;
                            end
                            default: begin
                                if (per_cnt == RTI_LAST) begin
                                    rsp_data_q  <= cap;
                                    rsp_valid_q <= 1'b1;
                                    state       <= S_RSP;
                                end else begin
                                    per_cnt <= per_cnt + 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Strobes and tdi decode from state, so they only move at tck period boundaries.
    assign vj_uir   = (state == S_UIR);
    assign vj_cdr   = (state == S_CDR);
    assign vj_sdr   = (state == S_SDR);
    assign vj_udr   = (state == S_UDR);
    assign vj_rti   = (state == S_RTI) || (state == S_IDLE) || (state == S_RSP);
    assign vj_tdi   = (state == S_SDR) && shift[0];
    assign vj_tck   = tck_q;
    assign vj_ir_in = ir_q;
    assign busy     = (state != S_IDLE);

    assign host.cmd_ready  = (state == S_IDLE);
    assign host.rsp_valid  = rsp_valid_q;
    assign host.rsp_data   = rsp_data_q;
    assign host.rsp_ir_out = rsp_ir_q;
endmodule

// File: tb/tb_nios_system_cpu_0_jtag_debug_host.sv
// Bench for the virtual-JTAG debug host: timeline model checked every cycle plus directed literal checks.
module tb_nios_system_cpu_0_jtag_debug_host;
    localparam int DRW  = 38;
    localparam int IRW  = 2;
    localparam int D0   = 2;
    localparam int R0   = 2;
    localparam int D1   = 1;
    localparam int R1   = 1;
    localparam int TOT0 = (3 + DRW + R0) * 2 * D0;
    localparam int TOT1 = (3 + DRW + R1) * 2 * D1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt++;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h at edge %0d", nm, a, e, ecnt);
    endtask

    // ---------------- instance 0: default parameters ----------------
    nios_system_cpu_0_jtag_debug_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) if0 ();
    logic busy0, tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;
    logic [IRW-1:0] ir_in0;
    logic [IRW-1:0] ir_out0 = '0;
    logic loop_en = 1'b0;
    logic tdo_tie = 1'b1;
    logic tdo_q   = 1'b0;
    int   sdr_edges = 0;

    assign tdo0 = loop_en ? tdo_q : tdo_tie;
    always @(posedge tck0) tdo_q <= tdi0;
    always @(posedge tck0) if (sdr0) sdr_edges++;

    nios_system_cpu_0_jtag_debug_host #(
        .TCK_DIV(D0), .DR_WIDTH(DRW), .IR_WIDTH(IRW), .RTI_CYCLES(R0)
    ) u0 (
        .clk(clk), .reset(reset), .host(if0), .busy(busy0),
        .vj_tck(tck0), .vj_tdi(tdi0), .vj_tdo(tdo0),
        .vj_ir_in(ir_in0), .vj_ir_out(ir_out0),
        .vj_uir(uir0), .vj_cdr(cdr0), .vj_sdr(sdr0), .vj_udr(udr0), .vj_rti(rti0)
    );

    // ---------------- instance 1: fast tck, short idle ----------------
    nios_system_cpu_0_jtag_debug_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) if1 ();
    logic busy1, tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;
    logic [IRW-1:0] ir_in1;
    logic [IRW-1:0] ir_out1 = 2'b11;
    logic tdo1 = 1'b1;

    nios_system_cpu_0_jtag_debug_host #(
        .TCK_DIV(D1), .DR_WIDTH(DRW), .IR_WIDTH(IRW), .RTI_CYCLES(R1)
    ) u1 (
        .clk(clk), .reset(reset), .host(if1), .busy(busy1),
        .vj_tck(tck1), .vj_tdi(tdi1), .vj_tdo(tdo1),
        .vj_ir_in(ir_in1), .vj_ir_out(ir_out1),
        .vj_uir(uir1), .vj_cdr(cdr1), .vj_sdr(sdr1), .vj_udr(udr1), .vj_rti(rti1)
    );

    // ---------------- timeline model + compare for instance 0 ----------------
    logic           act = 1'b0;
    int             t_acc, mc, mp, mph;
    logic [4:0]     msv;
    logic [DRW-1:0] m_data, m_exp, m_tmp;
    logic [IRW-1:0] m_ir, m_irout;
    logic [IRW-1:0] m_last_ir = '0;
    logic           m_tdi;

    always @(negedge clk) begin
        if (reset) begin
            act       = 1'b0;
            m_last_ir = '0;
        end else if (act) begin
            mc = ecnt - t_acc;
            if (mc < TOT0) begin
                mp  = mc / (2 * D0);
                mph = mc % (2 * D0);
                if (mp == 0)             msv = 5'b10000;
                else if (mp == 1)        msv = 5'b01000;
                else if (mp < 2 + DRW)   msv = 5'b00100;
                else if (mp == 2 + DRW)  msv = 5'b00010;
                else                     msv = 5'b00001;
                m_tdi = (mp >= 2 && mp < 2 + DRW) ? m_data[mp-2] : 1'b0;
                chk("tck", tck0, mph >= D0);
                chk("strobes", {uir0, cdr0, sdr0, udr0, rti0}, msv);
                chk("tdi", tdi0, m_tdi);
                chk("ir_in_scan", ir_in0, m_ir);
                chk("flow_scan", {if0.cmd_ready, busy0, if0.rsp_valid}, 3'b010);
            end else begin
                chk("flow_rsp", {if0.cmd_ready, busy0, if0.rsp_valid, tck0, tdi0}, 5'b01100);
                chk("strobes_rsp", {uir0, cdr0, sdr0, udr0, rti0}, 5'b00001);
                chk("rsp_data", if0.rsp_data, m_exp);
                chk("rsp_ir_out", if0.rsp_ir_out, m_irout);
                chk("ir_in_rsp", ir_in0, m_ir);
                if (if0.rsp_ready) begin
                    act       = 1'b0;
                    m_last_ir = m_ir;
                end
            end
        end else begin
            chk("flow_idle", {if0.cmd_ready, busy0, if0.rsp_valid, tck0, tdi0}, 5'b10000);
            chk("strobes_idle", {uir0, cdr0, sdr0, udr0, rti0}, 5'b00001);
            chk("ir_in_idle", ir_in0, m_last_ir);
            if (if0.cmd_valid) begin
                act     = 1'b1;
                t_acc   = ecnt + 1;
                m_data  = if0.cmd_data;
                m_ir    = if0.cmd_ir;
                m_irout = ir_out0;
                m_tmp   = if0.cmd_data << 1;
                m_exp   = loop_en ? m_tmp : {DRW{tdo_tie}};
            end
        end
    end

    // ---------------- event recorder for instance 1 ----------------
    int             acc1[$];
    int             rise1[$];
    int             hs1[$];
    logic [DRW-1:0] dat1[$];
    logic [IRW-1:0] iro1[$];
    logic           prev_v1 = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_v1 = 1'b0;
        end else begin
            if (if1.cmd_valid && if1.cmd_ready) acc1.push_back(ecnt + 1);
            if (if1.rsp_valid && !prev_v1) begin
                rise1.push_back(ecnt);
                dat1.push_back(if1.rsp_data);
                iro1.push_back(if1.rsp_ir_out);
            end
            if (if1.rsp_valid && if1.rsp_ready) hs1.push_back(ecnt + 1);
            prev_v1 = if1.rsp_valid;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send0(input logic [IRW-1:0] ir, input logic [DRW-1:0] d, output int acc);
        int n;
        if0.cmd_ir    = ir;
        if0.cmd_data  = d;
        if0.cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if0.cmd_ready && n < 1000);
        if (!if0.cmd_ready) chk("accept_timeout", 0, 1);
        acc = ecnt + 1;
        @(posedge clk);
        #1 if0.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp0(output int rise);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if0.rsp_valid && n < 2000);
        if (!if0.rsp_valid) chk("rsp_timeout", 0, 1);
        rise = ecnt;
    endtask

    int   acc, rise, n;
    logic saw;
    logic [DRW-1:0] hold_dat;

    initial begin
        if0.cmd_valid = 1'b0; if0.cmd_ir = '0; if0.cmd_data = '0; if0.rsp_ready = 1'b0;
        if1.cmd_valid = 1'b0; if1.cmd_ir = '0; if1.cmd_data = '0; if1.rsp_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {if0.cmd_ready, busy0, if0.rsp_valid, tck0, tdi0, rti0}, 6'b100001);
        chk("reset_rsp_data", if0.rsp_data, 0);
        chk("reset_ir", {ir_in0, if0.rsp_ir_out}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Tied-high tdo, IR status 2'b10, response held off for 50 cycles
        tdo_tie = 1'b1; loop_en = 1'b0; ir_out0 = 2'b10;
        send0(2'b01, 38'h0, acc);
        wait_rsp0(rise);
        chk("latency_default", rise - acc, 172);
        chk("rsp_all_ones", if0.rsp_data, 38'h3F_FFFF_FFFF);
        chk("rsp_ir_out_lit", if0.rsp_ir_out, 2'b10);
        hold_dat = if0.rsp_data;
        repeat (50) @(negedge clk);
        chk("hold_flags", {if0.rsp_valid, if0.cmd_ready, tck0}, 3'b100);
        chk("hold_data", if0.rsp_data, hold_dat);
        chk("ir_in_held", ir_in0, 2'b01);
        @(posedge clk);
        #1 if0.rsp_ready = 1'b1;
        @(posedge clk);
        #1 if0.rsp_ready = 1'b0;
        chk("after_hs", {if0.rsp_valid, if0.cmd_ready}, 2'b01);

        // Loopback with rsp_ready already high when the response appears
        loop_en = 1'b1; ir_out0 = 2'b01; sdr_edges = 0;
        if0.rsp_ready = 1'b1;
        send0(2'b11, 38'h2A_5A5A_A5A5, acc);
        wait_rsp0(rise);
        chk("loopback_data", if0.rsp_data, 38'h14_B4B5_4B4A);
        chk("sdr_tck_edges", sdr_edges, 38);
        chk("rise_cmd_ready", if0.cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("same_cycle_hs", {if0.rsp_valid, if0.cmd_ready, busy0}, 3'b010);
        chk("ir_in_after", ir_in0, 2'b11);
        if0.rsp_ready = 1'b0;
        loop_en = 1'b0;

        // Reset during SDR bit 20: abort, no response afterwards
        tdo_tie = 1'b0; if0.rsp_ready = 1'b1;
        send0(2'b10, 38'h15_5555_5555, acc);
        n = 0;
        while (ecnt < acc + 90 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("in_sdr_bit20", sdr0, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_outs", {if0.cmd_ready, busy0, if0.rsp_valid, tck0, tdi0}, 5'b10000);
        chk("abort_strobes", {uir0, cdr0, sdr0, udr0, rti0}, 5'b00001);
        chk("abort_regs", {ir_in0, if0.rsp_ir_out, if0.rsp_data}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        saw = 1'b0;
        repeat (250) begin
            @(negedge clk);
            if (if0.rsp_valid) saw = 1'b1;
        end
        chk("no_rsp_after_abort", saw, 0);

        // TCK_DIV=1 instance: request held high across two back-to-back scans
        if1.cmd_ir = 2'b01; if1.cmd_data = 38'h0F_0F0F_0F0F; if1.cmd_valid = 1'b1;
        n = 0;
        while (acc1.size() < 2 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1 if1.cmd_valid = 1'b0;
        n = 0;
        while (rise1.size() < 2 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        if (acc1.size() == 2 && rise1.size() == 2 && hs1.size() == 2) begin
            chk("fast_latency0", rise1[0] - acc1[0], TOT1);
            chk("fast_latency1", rise1[1] - acc1[1], 84);
            chk("fast_hs_same", hs1[0] - rise1[0], 1);
            chk("fast_reaccept", acc1[1] - hs1[0], 1);
            chk("fast_data", dat1[0], 38'h3F_FFFF_FFFF);
            chk("fast_ir_out", iro1[1], 2'b11);
        end else begin
            chk("fast_event_count", {acc1.size(), rise1.size(), hs1.size()}, {32'd2, 32'd2, 32'd2});
        end
        chk("fast_idle", {if1.cmd_ready, busy1, if1.rsp_valid, ir_in1}, 5'b10001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end
endmodule
